// File: rtl/lr35902_irq_pkg.sv
// Shared constants and types for the LR35902 interrupt controller.
package lr35902_irq_pkg;

  // Interrupt source indices; lower index means higher priority.
  localparam int NUM_IRQ    = 5;
  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  // I/O page offsets of the flag and enable registers, and the vector of source 0.
  localparam logic [7:0] IRQ_IF_ADR   = 8'h0f;
  localparam logic [7:0] IRQ_IE_ADR   = 8'hff;
  localparam logic [7:0] IRQ_VEC_BASE = 8'h40;

  // CPU handshake state.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_DISPATCH = 2'd2
  } irq_state_e;

endpackage

// File: rtl/lr35902_irq_prio.sv
// Fixed-priority encoder: the lowest set bit of pend wins.
module lr35902_irq_prio
  import lr35902_irq_pkg::*;
(
  input  logic [NUM_IRQ-1:0] pend,
  output logic               valid,
  output logic [2:0]         idx
);

  // Scan from the lowest-priority bit down so the lowest index is written last.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    valid = |pend;
    idx   = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/lr35902_irq_ctrl.sv
// Interrupt controller: edge-detects peripheral lines into IF, masks with IE
// and ime, and runs the request/acknowledge handshake with the CPU core.
module lr35902_irq_ctrl
  import lr35902_irq_pkg::*;
#(
  parameter logic [7:0] IF_ADR   = IRQ_IF_ADR,
  parameter logic [7:0] IE_ADR   = IRQ_IE_ADR,
  parameter logic [7:0] VEC_BASE = IRQ_VEC_BASE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] adr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       read,
  input  logic       write,
  input  logic       irq_vblank,
  input  logic       irq_stat,
  input  logic       irq_timer,
  input  logic       irq_serial,
  input  logic       irq_joypad,
  input  logic       ime,
  output logic       int_req,
  input  logic       int_ack,
  output logic [7:0] int_vec,
  output logic       wake
);

  logic [NUM_IRQ-1:0] lines;
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] if_q, if_d, if_wr;
  logic [7:0]         ie_q, ie_wr;
  logic [7:0]         dout_q;
  logic [7:0]         int_vec_q;
  logic [NUM_IRQ-1:0] pend_q, pend_now;
  logic               now_valid;
  logic [2:0]         now_idx;
  logic               wr_if, wr_ie, dispatch;
  irq_state_e         state_q, state_d;

  assign lines = {irq_joypad, irq_serial, irq_timer, irq_stat, irq_vblank};
  assign rise  = lines & ~prev_q;

  assign wr_if = write && (adr == IF_ADR);
  assign wr_ie = write && (adr == IE_ADR);

  // Register contents as they would be after this cycle's CPU write; the
  // dispatch decision uses these so a same-cycle write can cancel it.
  assign if_wr = wr_if ? din[NUM_IRQ-1:0] : if_q;
  assign ie_wr = wr_ie ? din : ie_q;

  assign pend_q   = ie_q[NUM_IRQ-1:0] & if_q;
  assign pend_now = ie_wr[NUM_IRQ-1:0] & if_wr;

  assign dispatch = (state_q == ST_REQ) && int_ack;

  lr35902_irq_prio u_prio (
    .pend  (pend_now),
    .valid (now_valid),
    .idx   (now_idx)
  );

  // Next IF: CPU write, then acknowledge clear, then edge sets on top so an
  // incoming event is never lost.
  always_comb begin
    if_d = if_wr;
    if (dispatch && now_valid) if_d[now_idx] = 1'b0;
    if_d = if_d | rise;
  end

  // Handshake next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if ((|pend_q) && ime) state_d = ST_REQ;
      ST_REQ: begin
        if (int_ack)                   state_d = ST_DISPATCH;
        else if (!(|pend_q) || !ime)   state_d = ST_IDLE;
      end
      ST_DISPATCH: if (!int_ack)       state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // State, flag/enable registers, edge history, vector and read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q   <= ST_IDLE;
      prev_q    <= '0;
      if_q      <= '0;
      ie_q      <= '0;
      int_vec_q <= 8'h00;
      dout_q    <= 8'hff;
    end else begin
      state_q <= state_d;
      prev_q  <= lines;
      if_q    <= if_d;
      ie_q    <= ie_wr;
      if (dispatch) begin
        int_vec_q <= now_valid ? (VEC_BASE + {2'b00, now_idx, 3'b000}) : 8'h00;
      end
      if (read) begin
        if (adr == IF_ADR)      dout_q <= {3'b111, if_q};
        else if (adr == IE_ADR) dout_q <= ie_q;
        else                    dout_q <= 8'hff;
      end
    end
  end

  assign int_req = (state_q == ST_REQ);
  assign int_vec = int_vec_q;
  assign dout    = dout_q;
  assign wake    = |pend_q;

endmodule

// File: tb/tb_lr35902_irq_ctrl.sv
// Self-checking bench for lr35902_irq_ctrl: register access table plus
// directed handshake sequences.
module tb_lr35902_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] adr, din, dout, int_vec;
  logic       read, write, ime, int_req, int_ack, wake;
  logic       irq_vblank, irq_stat, irq_timer, irq_serial, irq_joypad;

  int n_checks = 0;
  int n_pass   = 0;

  lr35902_irq_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .adr        (adr),
    .din        (din),
    .dout       (dout),
    .read       (read),
    .write      (write),
    .irq_vblank (irq_vblank),
    .irq_stat   (irq_stat),
    .irq_timer  (irq_timer),
    .irq_serial (irq_serial),
    .irq_joypad (irq_joypad),
    .ime        (ime),
    .int_req    (int_req),
    .int_ack    (int_ack),
    .int_vec    (int_vec),
    .wake       (wake)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] adr;
    logic [7:0] din;
    logic       wr;
    logic       rd;
    logic [7:0] exp_dout;
    logic       exp_wake;
  } vec_t;

  localparam int NVEC = 15;
  vec_t tbl [NVEC];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    adr = a; din = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic rd_reg(input logic [7:0] a);
    adr = a; read = 1'b1;
    tick();
    read = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; adr = 8'h00; din = 8'h00; read = 1'b0; write = 1'b0;
    ime = 1'b0; int_ack = 1'b0;
    irq_vblank = 1'b0; irq_stat = 1'b0; irq_timer = 1'b0;
    irq_serial = 1'b0; irq_joypad = 1'b0;

    //            adr    din    wr    rd    dout   wake
    tbl[0]  = '{8'h0f, 8'h00, 1'b0, 1'b1, 8'he0, 1'b0};
    tbl[1]  = '{8'hff, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
    tbl[2]  = '{8'hff, 8'hff, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{8'hff, 8'h00, 1'b0, 1'b1, 8'hff, 1'b0};
    tbl[4]  = '{8'h0f, 8'hff, 1'b1, 1'b0, 8'hff, 1'b1};
    tbl[5]  = '{8'h0f, 8'h00, 1'b0, 1'b1, 8'hff, 1'b1};
    tbl[6]  = '{8'h0f, 8'h0a, 1'b1, 1'b0, 8'hff, 1'b1};
    tbl[7]  = '{8'h0f, 8'h00, 1'b0, 1'b1, 8'hea, 1'b1};
    tbl[8]  = '{8'h10, 8'h00, 1'b0, 1'b1, 8'hff, 1'b1};
    tbl[9]  = '{8'h10, 8'h00, 1'b1, 1'b0, 8'hff, 1'b1};
    tbl[10] = '{8'h0f, 8'h00, 1'b0, 1'b1, 8'hea, 1'b1};
    tbl[11] = '{8'hff, 8'h05, 1'b1, 1'b0, 8'hea, 1'b0};
    tbl[12] = '{8'hff, 8'h00, 1'b0, 1'b1, 8'h05, 1'b0};
    tbl[13] = '{8'h0f, 8'h00, 1'b1, 1'b0, 8'h05, 1'b0};
    tbl[14] = '{8'h0f, 8'h00, 1'b0, 1'b1, 8'he0, 1'b0};

    // Reset state.
    #12;
    check("rst_int_req", {7'd0, int_req}, 8'h00);
    check("rst_wake",    {7'd0, wake},    8'h00);
    check("rst_dout",    dout,            8'hff);
    check("rst_int_vec", int_vec,         8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Register access table (ime low, all lines low).
    for (int i = 0; i < NVEC; i++) begin
      adr = tbl[i].adr; din = tbl[i].din; write = tbl[i].wr; read = tbl[i].rd;
      tick();
      write = 1'b0; read = 1'b0;
      check($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
      check($sformatf("tbl%0d_wake", i), {7'd0, wake}, {7'd0, tbl[i].exp_wake});
      check($sformatf("tbl%0d_req", i), {7'd0, int_req}, 8'h00);
    end

    // Vblank handshake.
    wr_reg(8'hff, 8'h01);
    ime = 1'b1;
    irq_vblank = 1'b1;
    tick();
    check("vb_req_edge1", {7'd0, int_req}, 8'h00);
    rd_reg(8'h0f);
    check("vb_if_set", dout, 8'he1);
    check("vb_req_edge2", {7'd0, int_req}, 8'h01);
    int_ack = 1'b1;
    tick();
    check("vb_vec", int_vec, 8'h40);
    check("vb_req_disp", {7'd0, int_req}, 8'h00);
    rd_reg(8'h0f);
    check("vb_if_clr", dout, 8'he0);
    int_ack = 1'b0;
    tick();
    check("vb_req_idle", {7'd0, int_req}, 8'h00);
    tick();
    check("vb_req_stay", {7'd0, int_req}, 8'h00);
    irq_vblank = 1'b0;

    // Simultaneous stat + timer: stat first, then timer.
    wr_reg(8'hff, 8'h1f);
    irq_stat = 1'b1; irq_timer = 1'b1;
    tick();
    tick();
    check("two_req1", {7'd0, int_req}, 8'h01);
    int_ack = 1'b1;
    tick();
    check("two_vec1", int_vec, 8'h48);
    int_ack = 1'b0;
    tick();
    tick();
    check("two_req2", {7'd0, int_req}, 8'h01);
    int_ack = 1'b1;
    tick();
    check("two_vec2", int_vec, 8'h50);
    int_ack = 1'b0;
    tick();
    rd_reg(8'h0f);
    check("two_if_end", dout, 8'he0);
    irq_stat = 1'b0; irq_timer = 1'b0;

    // ime gating versus wake.
    ime = 1'b0;
    wr_reg(8'hff, 8'h04);
    irq_timer = 1'b1;
    tick();
    tick();
    check("ime0_req",  {7'd0, int_req}, 8'h00);
    check("ime0_wake", {7'd0, wake},    8'h01);
    ime = 1'b1;
    tick();
    check("ime1_req", {7'd0, int_req}, 8'h01);
    int_ack = 1'b1;
    tick();
    check("ime1_vec", int_vec, 8'h50);
    int_ack = 1'b0;
    tick();
    irq_timer = 1'b0;

    // Ack in the same cycle as an IF clear: dispatch with null vector.
    wr_reg(8'hff, 8'h01);
    irq_vblank = 1'b1;
    tick();
    tick();
    check("cancel_req", {7'd0, int_req}, 8'h01);
    int_ack = 1'b1;
    adr = 8'h0f; din = 8'h00; write = 1'b1;
    tick();
    write = 1'b0;
    check("cancel_vec", int_vec, 8'h00);
    check("cancel_req_disp", {7'd0, int_req}, 8'h00);
    tick();
    check("cancel_req_hold", {7'd0, int_req}, 8'h00);
    int_ack = 1'b0;
    tick();
    tick();
    check("cancel_req_after", {7'd0, int_req}, 8'h00);
    irq_vblank = 1'b0;

    // Joypad edge coinciding with the ack that clears IF[4].
    wr_reg(8'hff, 8'h10);
    irq_joypad = 1'b1;
    tick();
    irq_joypad = 1'b0;
    tick();
    check("joy_req", {7'd0, int_req}, 8'h01);
    int_ack = 1'b1; irq_joypad = 1'b1;
    tick();
    check("joy_vec", int_vec, 8'h60);
    rd_reg(8'h0f);
    check("joy_if_kept", dout, 8'hf0);
    int_ack = 1'b0;
    tick();
    check("joy_req_idle", {7'd0, int_req}, 8'h00);
    tick();
    check("joy_rereq", {7'd0, int_req}, 8'h01);

    // Asynchronous reset in the middle of DISPATCH.
    int_ack = 1'b1;
    tick();
    check("mid_req_disp", {7'd0, int_req}, 8'h00);
    check("mid_vec", int_vec, 8'h60);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_int_req", {7'd0, int_req}, 8'h00);
    check("arst_int_vec", int_vec, 8'h00);
    check("arst_dout", dout, 8'hff);
    check("arst_wake", {7'd0, wake}, 8'h00);
    int_ack = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Joypad still high at reset release sets IF[4] on the first clock.
    tick();
    rd_reg(8'h0f);
    check("rel_if_joy", dout, 8'hf0);
    check("rel_req", {7'd0, int_req}, 8'h00);
    irq_joypad = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lr35902_irq_ctrl.md
Name: lr35902_irq_ctrl

Overview:
- Interrupt controller sitting directly downstream of the PPU, timer, serial and joypad blocks.
- Consumes their level interrupt lines (irq_vblank, irq_stat, ...), edge-detects them into the IF register (I/O 0x0F), masks with IE (0xFF) and the CPU's IME flag.
- Presents a prioritised request/vector to the CPU core through a request/acknowledge handshake.
- Also provides the HALT wake-up signal.

Parameters:
- IF_ADR, 8'h0f, I/O page offset of IF.
- IE_ADR, 8'hff, I/O page offset of IE.
- VEC_BASE, 8'h40, vector of source 0; source n vector = VEC_BASE + 8*n.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- adr  in  8  I/O page offset (0xFF00 + adr).
- din  in  8  write data.
- dout  out  8  read data.
- read  in  1  read strobe.
- write  in  1  write strobe.
- irq_vblank  in  1  source 0 (level from PPU).
- irq_stat  in  1  source 1 (level from PPU).
- irq_timer  in  1  source 2.
- irq_serial  in  1  source 3.
- irq_joypad  in  1  source 4.
- ime  in  1  CPU master enable.
- int_req  out  1  interrupt request to CPU.
- int_ack  in  1  CPU acknowledge; held high until int_req drops.
- int_vec  out  8  dispatch vector (low byte; high byte is 0x00).
- wake  out  1  (IE & IF & 5'h1f) != 0, independent of ime; for HALT exit.

Behaviour:
- Reset (async on reset_n low):
  - IF=0, IE=0, dout=8'hff, int_req=0, int_vec=0, FSM=IDLE, edge history regs=0.
  - A source already high at reset release sets its IF bit on the first clock.
- Edge detect:
  - Per source, prev<=line each clk; rise = line & ~prev.
  - A rise sets IF[n] at the same clk edge (1 cycle after the line is sampled high).
  - Levels held high do not re-set the bit after it is cleared.
- Register writes:
  - write & adr==IF_ADR: IF[4:0]<=din[4:0].
  - write & adr==IE_ADR: IE[7:0]<=din.
  - Other addresses are ignored.
- Register reads:
  - On clk with read=1, dout<=register value; dout holds between reads.
  - IF reads {3'b111, IF[4:0]}; IE reads all 8 bits; any other adr reads 8'hff.
- Set/clear priority within a cycle:
  - An edge set beats a CPU write clear and an ack clear of the same bit (the event is never lost).
  - A write of 1 and an edge on the same bit both give 1.
- Pending: P = IE[4:0] & IF[4:0]. Priority: lowest index wins (vblank highest).
- FSM (int_req registered, =1 only in REQ):
  - IDLE: if P!=0 & ime -> REQ.
  - REQ: if int_ack -> DISPATCH. Else if P==0 or !ime -> IDLE (request withdrawn, no clear).
  - On the REQ->DISPATCH transition, recompute highest pending at that cycle:
    - If one exists: int_vec<=VEC_BASE+8*n and clear IF[n] (subject to the edge-set priority above).
    - If P==0 in that cycle (e.g. cancelled by an IF/IE write in the same cycle): int_vec<=8'h00, nothing cleared.
  - DISPATCH: int_req=0, int_vec frozen. When int_ack==0 -> IDLE. Re-request possible the cycle after.
- int_vec holds its last value outside DISPATCH.
- Reset mid-handshake returns to IDLE immediately; the CPU must tolerate int_req dropping.
- wake is combinational from registered IF/IE.

Decomposition:
- Shared package lr35902_irq_pkg:
  - Source indices IRQ_VBLANK=0 .. IRQ_JOYPAD=4 and NUM_IRQ=5.
  - Address constants, VEC_BASE.
  - FSM state encoding (IDLE/REQ/DISPATCH).
- One sub-module: lr35902_irq_prio, a combinational 5-bit fixed-priority encoder (valid + 3-bit index).

Test Plan:
- Reset release with all lines low, read IF -> dout=8'he0; read IE -> 8'h00; int_req=0, wake=0.
- IE<=8'h01, ime=1, pulse irq_vblank -> IF=8'he1, int_req=1 two clocks after the edge. Assert int_ack -> int_vec=8'h40, IF=8'he0. Drop int_ack -> FSM IDLE, int_req stays 0.
- IE<=8'h1f, rise irq_timer and irq_stat in the same cycle, ime=1 -> ack gives int_vec=8'h48. Second handshake gives 8'h50; IF ends 8'he0.
- ime=0, IE=8'h04, timer edge -> int_req=0, wake=1. Set ime=1 -> int_req=1 next cycle.
- In REQ (vblank pending), write IF<=0 in the same cycle int_ack rises -> int_vec=8'h00, no bit cleared, int_req low until int_ack drops.
- irq_joypad rises in the same cycle as an ack clearing IF[4] -> IF[4] remains 1 and int_req reasserts after DISPATCH exits. Separately, reset_n low during DISPATCH -> all outputs return to reset values asynchronously.
